// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register offsets, STATUS bit indices and drain-FSM states for the UART TX buffer
package uart_pkg;

  localparam logic [31:0] UART_DATA_OFS   = 32'h0;
  localparam logic [31:0] UART_STATUS_OFS = 32'h4;

  localparam int STAT_TX_READY  = 0;
  localparam int STAT_SPACE     = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_FULL      = 3;
  localparam int STAT_OVF       = 4;
  // Count owns bits 15:8, so the enable reads back in spare bit 5 but is written via bit 8.
  localparam int STAT_IRQ_EN_RD = 5;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_IRQ_EN_WR = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_BUSY = 2'd2
  } drain_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - DEPTH x 8 synchronous FIFO; a push into a full FIFO is accepted only alongside a pop
module sync_fifo #(
  parameter int DEPTH      = 16,
  parameter int DEPTH_BITS = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                push_i,
  input  logic [7:0]          wdata_i,
  input  logic                pop_i,
  output logic [7:0]          rdata_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [DEPTH_BITS:0] count_o
);

  localparam logic [DEPTH_BITS:0] FULL_CNT = (DEPTH_BITS + 1)'(DEPTH);

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_BITS:0]   count_q;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + DEPTH_BITS'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + DEPTH_BITS'(1);
      count_q <= count_q + (DEPTH_BITS + 1)'(do_push) - (DEPTH_BITS + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - memory-mapped UART transmit buffer with drain FSM
// Optional low-water interrupt built only when TX_FIFO_IRQ_EN is defined.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DEPTH_BITS = $clog2(DEPTH),
  parameter int IRQ_LEVEL  = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_send_o,
  input  logic        tx_ready_i,
  output logic        irq_o
);

  logic                is_status, wr, push, pop;
  logic                full, empty;
  logic [DEPTH_BITS:0] count;
  logic [7:0]          head;
  drain_state_e        state_q, state_d;
  logic                wait_q, wait_d;
  logic                tx_send_q, ovf_q, rvalid_q;
  logic [7:0]          tx_data_q;
  logic [31:0]         rdata_q, status;
  logic                irq_en;
  logic                unused_bits;

  assign unused_bits = ^{addr_i[31:3], addr_i[1:0], be_i[3:1], wdata_i[31:8], irq_en};

  assign is_status = (addr_i[2] == UART_STATUS_OFS[2]);
  assign wr        = req_i && we_i;
  assign push      = wr && !is_status && be_i[0];

  sync_fifo #(
    .DEPTH      (DEPTH),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .wdata_i (wdata_i[7:0]),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    status                           = '0;
    status[STAT_TX_READY]            = tx_ready_i;
    status[STAT_SPACE]               = !full;
    status[STAT_EMPTY]               = empty;
    status[STAT_FULL]                = full;
    status[STAT_OVF]                 = ovf_q;
    status[STAT_IRQ_EN_RD]           = irq_en;
    status[STAT_COUNT_LSB +: 8]      = 8'(count);
  end

  // SEND gives the uart two cycles to drop ready; if it never does the byte is treated as sent.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty && tx_ready_i) begin
          pop     = 1'b1;
          state_d = ST_SEND;
          wait_d  = 1'b0;
        end
      end
      ST_SEND: begin
        if (!tx_ready_i)  state_d = ST_BUSY;
        else if (wait_q)  state_d = ST_IDLE;
        else              wait_d  = 1'b1;
      end
      ST_BUSY: begin
        if (tx_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      wait_q    <= 1'b0;
      tx_send_q <= 1'b0;
      tx_data_q <= '0;
      ovf_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      tx_send_q <= pop;
      if (pop) tx_data_q <= head;
      rvalid_q  <= req_i;
      rdata_q   <= (req_i && !we_i && is_status) ? status : '0;
      if (push && full && !pop) ovf_q <= 1'b1;
      if (wr && is_status && wdata_i[STAT_OVF]) ovf_q <= 1'b0;
    end
  end

`ifdef TX_FIFO_IRQ_EN
  localparam logic [DEPTH_BITS:0] IRQ_LVL = (DEPTH_BITS + 1)'(IRQ_LEVEL);
  logic irq_en_q, irq_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr && is_status) irq_en_q <= wdata_i[STAT_IRQ_EN_WR];
      irq_q <= irq_en_q && (count <= IRQ_LVL);
    end
  end

  assign irq_en = irq_en_q;
  assign irq_o  = irq_q;
`else
  assign irq_en = 1'b0;
  assign irq_o  = 1'b0;
`endif

  assign gnt_o     = req_i;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign tx_data_o = tx_data_q;
  assign tx_send_o = tx_send_q;

endmodule
